param_rotator: RTL and testbench
================================

Name: param_rotator

Overview:
Parametrised, loadable rotating register: the successor to the fixed 4-bit single-step rotator and enable register. It holds a WIDTH-bit word and rotates it left or right by a programmable amount for a programmable number of enabled steps. It uses a start/busy/done handshake and tracks the cumulative rotation offset. It sits between a data source and consumers that need a multi-step rotated word, such as one-hot ring pointers.

Parameters:
WIDTH, 4, data word width in bits; must be >= 2, need not be a power of two.
AMT_W, 3, width of the rotate-amount input; amount is taken modulo WIDTH.
STEP_W, 8, width of the step-count input; up to 2^STEP_W-1 steps per run.
POS_W, clog2(WIDTH), width of the offset output; derived and not overridden.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  step enable; RUN advances only on edges where en=1.
load  in  1  IDLE only: capture data_in.
data_in  in  WIDTH  word to load.
start  in  1  IDLE only: begin a run using dir/amt/steps.
dir  in  1  0 = rotate right (LSB wraps into MSB), 1 = rotate left.
amt  in  AMT_W  bits rotated per step.
steps  in  STEP_W  number of steps in the run.
data_out  out  WIDTH  current register word.
pos  out  POS_W  cumulative right-rotation offset since last load, modulo WIDTH.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset: synchronous, active-high; takes priority over all other inputs, including mid-run.
  - Outputs: data_out=0, pos=0, busy=0, done=0.
  - State: IDLE; internal remaining-step count = 0.
- States are IDLE and RUN.
- done defaults to 0 every cycle unless set as described below.
- IDLE, load=1: data_out<=data_in and pos<=0 on the next edge.
  - load has priority over start in the same cycle; that start is dropped, not queued.
- IDLE, start=1 and load=0: latch dir, eff=amt mod WIDTH, and rem=steps.
  - steps==0: stay in IDLE, done=1 on the next cycle, data_out and pos unchanged, busy stays 0.
  - steps>0: go to RUN; busy=1 from the next cycle.
- RUN, edge with en=1:
  - data_out <= data_out rotated by eff in the latched dir.
  - pos <= (pos + eff) mod WIDTH for right; (pos - eff + WIDTH) mod WIDTH for left.
  - rem <= rem-1.
- RUN, edge with en=0: all state held, no step consumed.
- Run completion: on the enabled edge where rem==1, apply the final rotation, set done=1 and busy=0, and return to IDLE.
  - done coincides with the final data_out value.
  - A new start is accepted on the cycle done is high (FSM is already in IDLE).
- Latency: a run of N steps with en held high makes busy high for exactly N cycles. done rises N edges after the start-accept edge.
- eff==0 (amt a multiple of WIDTH): the step still counts; data_out and pos are unchanged.
- load, start, dir, amt and steps are ignored while in RUN. The latched values are not affected by changes to these inputs.
- pos arithmetic is true modulo WIDTH, not bit truncation, so non-power-of-two WIDTH is correct.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package contains:
  - state enum {IDLE, RUN};
  - constants ROT_RIGHT=1'b0 and ROT_LEFT=1'b1;
  - a function for the modulo-WIDTH add/subtract on pos.
- One natural sub-module: barrel_rot, a combinational rotate of a WIDTH-bit word by eff in either direction.
  - Implemented as log2 stages or as a concatenate-and-select.
  - Reused for the single-step case.

Test Plan:
1. Reset, then load=1 with data_in=4'b1001 -> data_out=1001, pos=0, busy=0, done=0.
2. From 1001, start with dir=0, amt=1, steps=1 -> one edge later data_out=1100, pos=1, done=1 for one cycle; busy=1 for 1 cycle.
3. From 1000 with pos=0, start with dir=1, amt=1, steps=3, en=1 -> data_out sequence 0001, 0010, 0100; done on the 3rd edge; final pos=1.
4. From 0001, start with dir=0, amt=5 (eff 1), steps=1 -> data_out=1000. Repeat with amt=4 -> data_out unchanged, pos unchanged, done still pulses.
5. Mid-run gating and ignored inputs:
   - Drop en low for 2 cycles mid-run -> data_out and rem hold, busy stays 1, run finishes 2 cycles later.
   - Assert load and start during RUN -> no effect.
6. Edge cases:
   - start with steps=0 -> done=1 next cycle, busy never rises.
   - Assert rst on the 2nd step of a 5-step run -> next cycle data_out=0, pos=0, busy=0, done=0, FSM in IDLE.
   - Simultaneous load and start in IDLE -> load taken, no run.

Source files
------------

// File: rtl/param_rotator_pkg.sv
// Shared types, constants and the modulo-WIDTH offset helper for param_rotator.
package param_rotator_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic ROT_RIGHT = 1'b0;
    localparam logic ROT_LEFT  = 1'b1;

    // Next rotation offset. Both pos and eff are already below width, so one
    // conditional subtract gives a true modulo for any width.
    function automatic int unsigned pos_step(int unsigned pos, int unsigned eff, logic dir,
                                             int unsigned width);
        int unsigned sum;
        if (dir == ROT_RIGHT) begin
            sum = pos + eff;
        end else begin
            sum = pos + width - eff;
        end
        if (sum >= width) begin
            sum = sum - width;
        end
        return sum;
    endfunction

endpackage

// File: rtl/param_rotator_barrel_rot.sv
// Combinational rotate of a WIDTH-bit word by eff_i (< WIDTH) in either direction.
module param_rotator_barrel_rot
    import param_rotator_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SH_W  = 2
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SH_W-1:0]  eff_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] data_o
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] shifted;

    // Doubled word: a shift of the concatenation selects the rotated window
    always_comb begin
        dbl     = {data_i, data_i};
        shifted = '0;
        data_o  = '0;
        if (dir_i == ROT_RIGHT) begin
            shifted = dbl >> eff_i;
            data_o  = shifted[WIDTH-1:0];
        end else begin
            shifted = dbl << eff_i;
            data_o  = shifted[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/param_rotator.sv
// Loadable rotating register: rotates by a programmable amount for a programmable
// number of enabled steps, with start/busy/done handshake and offset tracking.
module param_rotator
    import param_rotator_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned AMT_W  = 3,
    parameter int unsigned STEP_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         load,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         start,
    input  logic                         dir,
    input  logic [AMT_W-1:0]             amt,
    input  logic [STEP_W-1:0]            steps,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(WIDTH)-1:0]     pos,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned POS_W = $clog2(WIDTH);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [POS_W-1:0]    eff_q, eff_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    rot_data;

    param_rotator_barrel_rot #(
        .WIDTH (WIDTH),
        .SH_W  (POS_W)
    ) u_barrel_rot (
        .data_i (data_q),
        .eff_i  (eff_q),
        .dir_i  (dir_q),
        .data_o (rot_data)
    );

    // Next-state: IDLE handles load/start, RUN consumes one step per enabled edge
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pos_d   = pos_q;
        eff_d   = eff_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    data_d = data_in;
                    pos_d  = '0;
                end else if (start) begin
                    dir_d = dir;
                    eff_d = POS_W'(32'(amt) % WIDTH);
                    rem_d = steps;
                    if (steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (en) begin
                    data_d = rot_data;
                    pos_d  = POS_W'(pos_step(32'(pos_q), 32'(eff_q), dir_q, WIDTH));
                    rem_d  = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            pos_q   <= '0;
            eff_q   <= '0;
            dir_q   <= ROT_RIGHT;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
            eff_q   <= eff_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign pos      = pos_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_param_rotator.sv
// Scoreboard bench for param_rotator (WIDTH=4): expected completion words are queued
// by the stimulus and checked by a monitor whenever done pulses.
module tb_param_rotator;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned AMT_W  = 3;
    localparam int unsigned STEP_W = 8;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] pos;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic [3:0]        data_in = '0;
    logic              start = 1'b0;
    logic              dir = 1'b0;
    logic [AMT_W-1:0]  amt = '0;
    logic [STEP_W-1:0] steps = '0;
    logic [3:0]        data_out;
    logic [1:0]        pos;
    logic              busy;
    logic              done;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    param_rotator #(
        .WIDTH  (WIDTH),
        .AMT_W  (AMT_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .data_in  (data_in),
        .start    (start),
        .dir      (dir),
        .amt      (amt),
        .steps    (steps),
        .data_out (data_out),
        .pos      (pos),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] p);
        exp_t e;
        e.data = d;
        e.pos  = p;
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_data", int'(data_out), int'(e.data));
                    chk("done_pos", int'(pos), int'(e.pos));
                    chk("done_busy_low", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_data", int'(data_out), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // 1: load 1001
        load = 1'b1; data_in = 4'b1001;
        tick();
        load = 1'b0;
        chk("t1_data", int'(data_out), 4'b1001);
        chk("t1_pos", int'(pos), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 0);

        // 2: right by 1, one step
        en = 1'b1;
        start = 1'b1; dir = 1'b0; amt = 3'd1; steps = 8'd1;
        push(4'b1100, 2'd1);
        tick();
        start = 1'b0;
        chk("t2_busy_run", int'(busy), 1);
        tick();
        chk("t2_busy_end", int'(busy), 0);
        chk("t2_done_hi", int'(done), 1);
        tick();
        chk("t2_done_pulse", int'(done), 0);

        // 3: left by 1, three steps from 1000
        load = 1'b1; data_in = 4'b1000;
        tick();
        load = 1'b0;
        start = 1'b1; dir = 1'b1; amt = 3'd1; steps = 8'd3;
        push(4'b0100, 2'd1);
        tick();
        start = 1'b0;
        chk("t3_accept_data", int'(data_out), 4'b1000);
        tick();
        chk("t3_s1", int'(data_out), 4'b0001);
        chk("t3_s1_pos", int'(pos), 3);
        tick();
        chk("t3_s2", int'(data_out), 4'b0010);
        chk("t3_s2_busy", int'(busy), 1);
        tick();
        chk("t3_s3", int'(data_out), 4'b0100);
        chk("t3_done", int'(done), 1);

        // 4: amt=5 reduces to 1; amt=4 reduces to 0
        load = 1'b1; data_in = 4'b0001;
        tick();
        load = 1'b0;
        start = 1'b1; dir = 1'b0; amt = 3'd5; steps = 8'd1;
        push(4'b1000, 2'd1);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dir = 1'b0; amt = 3'd4; steps = 8'd1;
        push(4'b1000, 2'd1);
        tick();
        start = 1'b0;
        tick();
        chk("t4_eff0_done", int'(done), 1);

        // 5: en gating and ignored inputs mid-run (right by 1, four steps, from 1000 pos 1)
        start = 1'b1; dir = 1'b0; amt = 3'd1; steps = 8'd4;
        push(4'b1000, 2'd1);
        tick();
        start = 1'b0;
        tick();
        chk("t5_s1", int'(data_out), 4'b0100);
        chk("t5_s1_pos", int'(pos), 2);
        en = 1'b0;
        load = 1'b1; data_in = 4'b1111;
        start = 1'b1; dir = 1'b1; amt = 3'd2; steps = 8'd7;
        tick();
        chk("t5_hold1", int'(data_out), 4'b0100);
        tick();
        chk("t5_hold2", int'(data_out), 4'b0100);
        chk("t5_hold_pos", int'(pos), 2);
        chk("t5_hold_busy", int'(busy), 1);
        load = 1'b0; start = 1'b0;
        en = 1'b1;
        tick();
        chk("t5_s2", int'(data_out), 4'b0010);
        tick();
        chk("t5_s3", int'(data_out), 4'b0001);
        chk("t5_s3_pos", int'(pos), 0);
        tick();
        chk("t5_end_done", int'(done), 1);

        // 6a: zero-step run
        start = 1'b1; dir = 1'b0; amt = 3'd1; steps = 8'd0;
        push(4'b1000, 2'd1);
        tick();
        start = 1'b0;
        chk("t6a_busy", int'(busy), 0);
        chk("t6a_done", int'(done), 1);
        tick();
        chk("t6a_done_pulse", int'(done), 0);

        // 6b: reset on the second step of a five-step run
        start = 1'b1; dir = 1'b0; amt = 3'd1; steps = 8'd5;
        tick();
        start = 1'b0;
        tick();
        chk("t6b_s1", int'(data_out), 4'b0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6b_data", int'(data_out), 0);
        chk("t6b_pos", int'(pos), 0);
        chk("t6b_busy", int'(busy), 0);
        chk("t6b_done", int'(done), 0);
        tick();
        chk("t6b_idle", int'(busy), 0);

        // 6c: load and start together: load wins, no run
        load = 1'b1; start = 1'b1; data_in = 4'b0110; dir = 1'b0; amt = 3'd1; steps = 8'd2;
        tick();
        load = 1'b0; start = 1'b0;
        chk("t6c_data", int'(data_out), 4'b0110);
        chk("t6c_busy", int'(busy), 0);
        tick();
        chk("t6c_busy2", int'(busy), 0);
        chk("t6c_done", int'(done), 0);
        chk("t6c_data2", int'(data_out), 4'b0110);

        tick();
        tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
